// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM for the convolution accelerator datapath.
// Loads kernel then input words from the host bus into the operand memories,
// walks every (output, tap) pair issuing one memory read per cycle, pipelines
// the mult/accumulate/commit strobes, then drains the output queue to the host.
// Never touches data: drives only enables, addresses and mode bits.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start/in_len/k_len  job request (sampled in IDLE only)
//   in_valid/in_ready   host word handshake during LOAD_K / LOAD_I
//   kr_wr_en/in_wr_en   memory write strobes, wr_word_idx = host word index
//   kr_rd_en/in_rd_en   memory read enables, kr_rd_addr = tap, in_rd_addr = o+t
//   en_mult/en_accum    multiplier / accumulator enables (issue + 1)
//   accum_first         accumulator loads instead of adds (tap 0)
//   out_wr_en           commit dot product to output queue (issue + 2)
//   out_rd_en/valid     output queue pop / result valid toward host
//   out_ready           host accepts a result
//   busy/done/err       status: not idle / job-end pulse / rejected-job pulse
module conv_sequencer #(
  parameter int IN_DEPTH       = 32,
  parameter int K_DEPTH        = 16,
  parameter int ELEMS_PER_WORD = 4,
  localparam int IAW = $clog2(IN_DEPTH),
  localparam int KAW = $clog2(K_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [IAW:0]   in_len,
  input  logic [KAW:0]   k_len,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           kr_wr_en,
  output logic           in_wr_en,
  output logic [IAW-1:0] wr_word_idx,
  output logic           kr_rd_en,
  output logic           in_rd_en,
  output logic [KAW-1:0] kr_rd_addr,
  output logic [IAW-1:0] in_rd_addr,
  output logic           en_mult,
  output logic           en_accum,
  output logic           accum_first,
  output logic           out_wr_en,
  output logic           out_rd_en,
  input  logic           out_ready,
  output logic           valid,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int WSH = $clog2(ELEMS_PER_WORD);
  localparam int CW  = IAW + 1;

  typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_I, COMPUTE, FLUSH, DRAIN, FIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  kw_q, kw_d, iw_q, iw_d, nout_q, nout_d, pops_q, pops_d;
  logic [KAW:0]   klen_q, klen_d;
  logic [IAW-1:0] wcnt_q, wcnt_d, o_q, o_d;
  logic [KAW-1:0] t_q, t_d;
  logic           flush_q, flush_d, valid_q, valid_d, err_q, err_d;
  // Issue pipeline: stage 1 drives mult/accum, stage 2 drives the commit.
  logic [2:1]     vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
  logic           first_q, first_d;

  logic           issue, t_last, o_last, job_bad;
  logic [CW-1:0]  kw_new, iw_new;

  assign job_bad = (k_len == '0) || (in_len == '0) || (CW'(k_len) > in_len);
  // Word counts rounded up: a partial last host word still has to be accepted.
  assign kw_new  = (CW'(k_len) + CW'(ELEMS_PER_WORD - 1)) >> WSH;
  assign iw_new  = (in_len + CW'(ELEMS_PER_WORD - 1)) >> WSH;
  assign t_last  = ({1'b0, t_q} == klen_q - 1'b1);
  assign o_last  = ({1'b0, o_q} == nout_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    kw_d        = kw_q;
    iw_d        = iw_q;
    nout_d      = nout_q;
    pops_d      = pops_q;
    klen_d      = klen_q;
    wcnt_d      = wcnt_q;
    o_d         = o_q;
    t_d         = t_q;
    flush_d     = flush_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    issue       = 1'b0;
    in_ready    = 1'b0;
    kr_wr_en    = 1'b0;
    in_wr_en    = 1'b0;
    wr_word_idx = '0;
    kr_rd_en    = 1'b0;
    in_rd_en    = 1'b0;
    kr_rd_addr  = '0;
    in_rd_addr  = '0;
    out_rd_en   = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (job_bad) err_d = 1'b1;
        else begin
          state_d = LOAD_K;
          klen_d  = k_len;
          kw_d    = kw_new;
          iw_d    = iw_new;
          nout_d  = in_len - CW'(k_len) + 1'b1;
          wcnt_d  = '0;
          o_d     = '0;
          t_d     = '0;
          pops_d  = '0;
          flush_d = 1'b0;
          valid_d = 1'b0;
        end
      end
      LOAD_K: begin
        in_ready    = 1'b1;
        wr_word_idx = wcnt_q;
        if (in_valid) begin
          kr_wr_en = 1'b1;
          if (CW'(wcnt_q) == kw_q - 1'b1) begin
            wcnt_d  = '0;
            state_d = LOAD_I;
          end else wcnt_d = wcnt_q + 1'b1;
        end
      end
      LOAD_I: begin
        in_ready    = 1'b1;
        wr_word_idx = wcnt_q;
        if (in_valid) begin
          in_wr_en = 1'b1;
          if (CW'(wcnt_q) == iw_q - 1'b1) begin
            wcnt_d  = '0;
            state_d = COMPUTE;
          end else wcnt_d = wcnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        issue      = 1'b1;
        kr_rd_en   = 1'b1;
        in_rd_en   = 1'b1;
        kr_rd_addr = t_q;
        in_rd_addr = o_q + IAW'(t_q);
        if (t_last) begin
          t_d = '0;
          if (o_last) state_d = FLUSH;
          else        o_d     = o_q + 1'b1;
        end else t_d = t_q + 1'b1;
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (pops_q != nout_q) out_rd_en = out_ready;
        // Pop only when the host takes the current result, so a pop both
        // retires the old result and presents the next one.
        if (out_rd_en) begin
          pops_d  = pops_q + 1'b1;
          valid_d = 1'b1;
        end else if (out_ready) valid_d = 1'b0;
        if ((pops_q == nout_q) && valid_q && out_ready) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    vld_pipe_d  = {vld_pipe_q[1], issue};
    last_pipe_d = {last_pipe_q[1], issue & t_last};
    first_d     = issue & (t_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      kw_q        <= '0;
      iw_q        <= '0;
      nout_q      <= '0;
      pops_q      <= '0;
      klen_q      <= '0;
      wcnt_q      <= '0;
      o_q         <= '0;
      t_q         <= '0;
      flush_q     <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kw_q        <= kw_d;
      iw_q        <= iw_d;
      nout_q      <= nout_d;
      pops_q      <= pops_d;
      klen_q      <= klen_d;
      wcnt_q      <= wcnt_d;
      o_q         <= o_d;
      t_q         <= t_d;
      flush_q     <= flush_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      first_q     <= first_d;
    end
  end

  assign en_mult     = vld_pipe_q[1];
  assign en_accum    = vld_pipe_q[1];
  assign accum_first = vld_pipe_q[1] & first_q;
  assign out_wr_en   = vld_pipe_q[2] & last_pipe_q[2];
  assign valid       = valid_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer. A behavioural datapath (memories, accumulator,
// output queue) follows the DUT strobes; reference convolution results are
// queued when a job is set up and compared as the host consumes them.
module tb_conv_sequencer;
  localparam int IN_DEPTH = 32, K_DEPTH = 16, EPW = 4, IAW = 5, KAW = 4;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [IAW:0] in_len = '0;
  logic [KAW:0] k_len = '0;
  logic in_ready, kr_wr_en, in_wr_en, kr_rd_en, in_rd_en;
  logic [IAW-1:0] wr_word_idx, in_rd_addr;
  logic [KAW-1:0] kr_rd_addr;
  logic en_mult, en_accum, accum_first, out_wr_en, out_rd_en, valid, busy, done, err;
  logic [63:0] outs;

  conv_sequencer #(.IN_DEPTH(IN_DEPTH), .K_DEPTH(K_DEPTH), .ELEMS_PER_WORD(EPW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_len(in_len), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .kr_wr_en(kr_wr_en), .in_wr_en(in_wr_en),
    .wr_word_idx(wr_word_idx), .kr_rd_en(kr_rd_en), .in_rd_en(in_rd_en),
    .kr_rd_addr(kr_rd_addr), .in_rd_addr(in_rd_addr), .en_mult(en_mult),
    .en_accum(en_accum), .accum_first(accum_first), .out_wr_en(out_wr_en),
    .out_rd_en(out_rd_en), .out_ready(out_ready), .valid(valid), .busy(busy),
    .done(done), .err(err));

  assign outs = 64'({in_ready, kr_wr_en, in_wr_en, wr_word_idx, kr_rd_en, in_rd_en,
                     kr_rd_addr, in_rd_addr, en_mult, en_accum, accum_first, out_wr_en,
                     out_rd_en, valid, busy, done, err});

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  typedef struct {int ia; int ka; bit first; bit last;} iss_t;

  int kmem[K_DEPTH], imem[IN_DEPTH], kv[32], iv[32];
  int hostq[$], resq[$], expq[$];
  iss_t issq[$];
  int acc, rk, ri, out_data, cyc = 0, td;
  int nwords, niss, naf, nwr, nres, ndone, nerr;
  int ivm = 0, rdm = 0;
  bit s1_iss, s1_first, s1_last, s2_last, pv, pr;

  always @(posedge clk) cyc <= cyc + 1;

  // Host-side handshake drivers: ivm 1 = random in_valid gaps,
  // rdm 1 = out_ready pattern 1,0,0,1,0,0,...
  always @(posedge clk) begin
    #1;
    in_valid  = (ivm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    out_ready = (rdm == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  always @(negedge clk) begin : mon
    iss_t e;
    int v, idx;
    bit nf, nl, iss;
    if (!rst) begin
      s1_iss = 0; s1_first = 0; s1_last = 0; s2_last = 0; pv = 0; pr = 0;
    end else begin
      if (en_mult || en_accum || s1_iss) begin
        chk("en_mult", en_mult, s1_iss);
        chk("en_accum", en_accum, s1_iss);
        chk("accum_first", accum_first, s1_iss & s1_first);
      end
      if (out_wr_en || s2_last) chk("out_wr_timing", out_wr_en, s2_last);
      if (out_wr_en) begin resq.push_back(acc); nwr++; end
      if (en_accum) acc = accum_first ? rk * ri : acc + rk * ri;
      if (accum_first) naf++;
      if (valid && out_ready) begin
        nres++;
        if (expq.size() > 0) chk("result", out_data, expq.pop_front());
        else chk("extra_result", 1, 0);
      end
      if (pv && !pr) chk("valid_hold", valid, 1);
      if (out_rd_en) begin
        chk("rd_gate", out_ready, 1);
        if (resq.size() > 0) out_data = resq.pop_front();
        else chk("queue_underflow", 1, 0);
      end
      if (in_valid && in_ready) nwords++;
      if (kr_wr_en || in_wr_en) begin
        chk("wr_gate", in_valid && in_ready, 1);
        for (int l = 0; l < EPW; l++) begin
          v = (hostq.size() > 0) ? hostq.pop_front() : -1;
          idx = int'(wr_word_idx) * EPW + l;
          if (kr_wr_en && idx < K_DEPTH) kmem[idx] = v;
          if (in_wr_en && idx < IN_DEPTH) imem[idx] = v;
        end
      end
      nf = 0; nl = 0; iss = in_rd_en || kr_rd_en;
      if (iss) begin
        niss++;
        chk("rd_pair", in_rd_en && kr_rd_en, 1);
        if (issq.size() > 0) begin
          e = issq.pop_front();
          chk("in_rd_addr", in_rd_addr, e.ia);
          chk("kr_rd_addr", kr_rd_addr, e.ka);
          nf = e.first; nl = e.last;
        end else chk("extra_issue", 1, 0);
        rk = kmem[kr_rd_addr];
        ri = imem[in_rd_addr];
      end
      s2_last = s1_iss & s1_last;
      s1_iss = iss; s1_first = nf; s1_last = nl;
      pv = valid; pr = out_ready;
      if (done) begin ndone++; td = cyc; end
      if (err) nerr++;
    end
  end

  task automatic clear_counts();
    nwords = 0; niss = 0; naf = 0; nwr = 0; nres = 0; ndone = 0; nerr = 0;
  endtask

  task automatic setup_job(input int il, input int kl);
    int kw, iw, s;
    iss_t e;
    clear_counts();
    hostq.delete(); resq.delete(); expq.delete(); issq.delete();
    acc = 0;
    kw = (kl + EPW - 1) / EPW; iw = (il + EPW - 1) / EPW;
    for (int i = 0; i < 32; i++) begin
      kv[i] = $urandom_range(0, 15); iv[i] = $urandom_range(0, 15);
    end
    for (int i = 0; i < kw * EPW; i++) hostq.push_back(i < kl ? kv[i] : 999);
    for (int i = 0; i < iw * EPW; i++) hostq.push_back(i < il ? iv[i] : 999);
    for (int o = 0; o <= il - kl; o++) begin
      s = 0;
      for (int t = 0; t < kl; t++) begin
        s += iv[o + t] * kv[t];
        e.ia = o + t; e.ka = t; e.first = (t == 0); e.last = (t == kl - 1);
        issq.push_back(e);
      end
      expq.push_back(s);
    end
  endtask

  task automatic pulse_start(input int il, input int kl);
    @(posedge clk); #1;
    start = 1'b1; in_len = 6'(il); k_len = 5'(kl);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int cnt = 0;
    while (ndone == 0 && cnt < bound) begin @(negedge clk); cnt++; end
    chk("done_seen", ndone > 0, 1);
  endtask

  task automatic run_job(input int il, input int kl, input int ivm_i, input int rdm_i, input bit spur);
    int kw, iw, n, t0, cnt;
    bit found;
    kw = (kl + EPW - 1) / EPW; iw = (il + EPW - 1) / EPW; n = il - kl + 1;
    setup_job(il, kl);
    ivm = ivm_i; rdm = rdm_i;
    @(posedge clk); #1;
    start = 1'b1; in_len = 6'(il); k_len = 5'(kl); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    fork
      wait_done(5000);
      begin
        if (spur) begin
          cnt = 0;
          while (!in_wr_en && cnt < 500) begin @(negedge clk); cnt++; end
          found = in_wr_en;
          chk("spur_in_load_i", found, 1);
          pulse_start(5, 2);
          cnt = 0;
          while (!out_rd_en && cnt < 1000) begin @(negedge clk); cnt++; end
          found = out_rd_en;
          chk("spur_in_drain", found, 1);
          pulse_start(4, 1);
        end
      end
    join
    if (ivm_i == 0 && rdm_i == 0) chk("done_latency", td - t0, kw + iw + n * kl + n + 4);
    repeat (3) @(negedge clk);
    chk("words", nwords, kw + iw);
    chk("issues", niss, n * kl);
    chk("accum_first_cnt", naf, n);
    chk("out_wr_cnt", nwr, n);
    chk("results", nres, n);
    chk("done_cnt", ndone, 1);
    chk("busy_end", busy, 0);
    chk("left_over", expq.size() + issq.size() + resq.size(), 0);
  endtask

  task automatic err_job(input int il, input int kl);
    clear_counts();
    ivm = 0; rdm = 0;
    pulse_start(il, kl);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(posedge clk); #1;
    chk("err_one_cycle", err, 0);
    repeat (3) @(negedge clk);
    chk("err_cnt", nerr, 1);
    chk("err_no_strobes", nwords + niss + nwr + naf + ndone, 0);
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    repeat (2) @(posedge clk); #1;
    chk("reset_outs", outs, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs, 0);

    run_job(8, 3, 0, 0, 0);
    err_job(4, 5);
    err_job(4, 0);
    err_job(0, 3);
    run_job(4, 1, 0, 0, 0);
    run_job(8, 3, 0, 1, 0);

    // Reset during COMPUTE at output index 2, then a fresh job.
    setup_job(8, 3);
    ivm = 0; rdm = 0;
    pulse_start(8, 3);
    cnt = 0;
    while (niss < 7 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("reach_o2", niss >= 7, 1);
    #2 rst = 1'b0;
    #1 chk("rst_async", outs, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold", outs, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", busy, 0);
    run_job(6, 2, 0, 0, 0);

    run_job(8, 3, 0, 0, 1);
    run_job(5, 5, 1, 0, 0);
    run_job(32, 16, 1, 1, 0);
    run_job(32, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
